// File: rtl/e_mult_pipe.sv
// -----------------------------------------------------------------------------
// e_mult_pipe -- pipelined integer multiply / accumulate unit (execute stage)
//
// Owns the architectural HI/LO pair. Every op, including MTHI/MTLO, walks the
// full LATENCY-deep pipeline and is applied to HI/LO in the last stage. This
// keeps program order and lets dependent accumulates issue back-to-back with
// no interlock.
//
// Parameters
//   WIDTH    operand width (even, >= 8)
//   LATENCY  acceptance-to-writeback cycles without stalls (2..16)
//
// Optional feature macro: MUL_ACC_EN
//   defined   : MADD/MADDU/MSUB/MSUBU accumulate into {HI,LO}
//   undefined : no accumulator; 010/100 act as MULTU, 011/101 act as MULT
//
// Ports
//   clock       system clock, rising edge
//   n_rst       asynchronous active-low reset
//   i_con_mul   op request strobe
//   i_op        opcode (see localparams below)
//   i_data_A    operand A, also the MTHI/MTLO source
//   i_data_B    operand B
//   i_stall     freeze the whole pipeline
//   i_flush     cancel every in-flight op (wins over stall)
//   o_data_Hi   HI register
//   o_data_Lo   LO register
//   o_con_mul   one-cycle pulse in the cycle after a writeback edge
//   o_busy      at least one op is in flight
//
// Handshake: there is no ready output. A request is taken on any rising edge
// where i_con_mul=1, i_stall=0 and i_flush=0; i_stall acts as "not ready",
// so a caller holds i_con_mul and its operands until a non-stalled,
// non-flushed edge. o_con_mul is a pure strobe with no back-pressure.
// -----------------------------------------------------------------------------
module e_mult_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 7
) (
  input  logic             clock,
  input  logic             n_rst,
  input  logic             i_con_mul,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_data_A,
  input  logic [WIDTH-1:0] i_data_B,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_data_Hi,
  output logic [WIDTH-1:0] o_data_Lo,
  output logic             o_con_mul,
  output logic             o_busy
);

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MADDU = 3'b010;
  localparam logic [2:0] OP_MADD  = 3'b011;
  localparam logic [2:0] OP_MSUBU = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  localparam int PW = 2 * WIDTH;

  // Stage 0: captured request. Stages 1..LATENCY-1 carry the finished
  // product (or the move source) together with the opcode.
  logic [LATENCY-1:0] valid_q;
  logic [WIDTH-1:0]   a0_q;
  logic [WIDTH-1:0]   b0_q;
  logic [2:0]         op0_q;
  logic [2:0]         op_q   [LATENCY-1:1];
  logic [PW-1:0]      prod_q [LATENCY-1:1];

  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               con_q;

  // ---------------------------------------------------------------------------
  // Stage 1 datapath: one full-width multiply of extended operands. The low
  // 2*WIDTH bits of the product of sign- (or zero-) extended operands are the
  // correct signed (or unsigned) result, so one multiplier serves both modes.
  // ---------------------------------------------------------------------------
  logic          signed_op;
  logic          move_op;
  logic [PW-1:0] ext_a;
  logic [PW-1:0] ext_b;
  logic [PW-1:0] mul_full;
  logic [PW-1:0] prod_nxt;

  always_comb begin
    signed_op = op0_q[0];
    move_op   = (op0_q == OP_MTHI) || (op0_q == OP_MTLO);
    ext_a     = signed_op ? {{WIDTH{a0_q[WIDTH-1]}}, a0_q} : {{WIDTH{1'b0}}, a0_q};
    ext_b     = signed_op ? {{WIDTH{b0_q[WIDTH-1]}}, b0_q} : {{WIDTH{1'b0}}, b0_q};
    mul_full  = ext_a * ext_b;
    // Moves reuse the product lane to carry A down to the writeback stage.
    prod_nxt  = move_op ? {{WIDTH{1'b0}}, a0_q} : mul_full;
  end

  // ---------------------------------------------------------------------------
  // Writeback stage: combine the final-stage payload with the HI/LO values
  // current at this edge, so back-to-back dependent ops see each other.
  // ---------------------------------------------------------------------------
  logic [2:0]       wb_op;
  logic [PW-1:0]    wb_prod;
  logic [PW-1:0]    hilo;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;

  always_comb begin
    wb_op   = op_q[LATENCY-1];
    wb_prod = prod_q[LATENCY-1];
    hilo    = {hi_q, lo_q};
    hi_nxt  = hi_q;
    lo_nxt  = lo_q;
    case (wb_op)
      OP_MTHI: hi_nxt = wb_prod[WIDTH-1:0];
      OP_MTLO: lo_nxt = wb_prod[WIDTH-1:0];
`ifdef MUL_ACC_EN
      OP_MADDU, OP_MADD: {hi_nxt, lo_nxt} = hilo + wb_prod;
      OP_MSUBU, OP_MSUB: {hi_nxt, lo_nxt} = hilo - wb_prod;
`endif
      // MULTU/MULT, and the accumulate opcodes when no accumulator is built.
      default: {hi_nxt, lo_nxt} = wb_prod;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline control. Priority: reset > flush > stall > advance.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      valid_q <= '0;
      a0_q    <= '0;
      b0_q    <= '0;
      op0_q   <= '0;
      for (int k = 1; k < LATENCY; k++) begin
        op_q[k]   <= '0;
        prod_q[k] <= '0;
      end
      hi_q  <= '0;
      lo_q  <= '0;
      con_q <= 1'b0;
    end else if (i_flush) begin
      // Cancels everything including an op at its writeback edge and a
      // same-cycle request; HI/LO untouched.
      valid_q <= '0;
      con_q   <= 1'b0;
    end else if (i_stall) begin
      con_q <= 1'b0;
    end else begin
      valid_q <= {valid_q[LATENCY-2:0], i_con_mul};
      if (i_con_mul) begin
        a0_q  <= i_data_A;
        b0_q  <= i_data_B;
        op0_q <= i_op;
      end
      op_q[1]   <= op0_q;
      prod_q[1] <= prod_nxt;
      for (int k = 2; k < LATENCY; k++) begin
        op_q[k]   <= op_q[k-1];
        prod_q[k] <= prod_q[k-1];
      end
      con_q <= valid_q[LATENCY-1];
      if (valid_q[LATENCY-1]) begin
        hi_q <= hi_nxt;
        lo_q <= lo_nxt;
      end
    end
  end

  assign o_data_Hi = hi_q;
  assign o_data_Lo = lo_q;
  assign o_con_mul = con_q;
  assign o_busy    = |valid_q;

endmodule

// File: tb/tb_e_mult_pipe.sv
// -----------------------------------------------------------------------------
// tb_e_mult_pipe -- self-checking bench for e_mult_pipe (WIDTH=32, LATENCY=7)
//
// The reference model keeps a list of in-flight ops with a countdown of
// remaining unstalled edges; an op whose countdown reaches zero is applied to
// the model HI/LO with plain 64-bit arithmetic. Follows MUL_ACC_EN like the DUT.
// -----------------------------------------------------------------------------
module tb_e_mult_pipe;

  localparam int W   = 32;
  localparam int LAT = 7;

  // ---------------------------------------------------------------- clock/reset
  logic clock = 1'b0;
  logic n_rst = 1'b0;
  always #5 clock = ~clock;

  logic          i_con_mul = 1'b0;
  logic [2:0]    i_op      = 3'd0;
  logic [W-1:0]  i_data_A  = '0;
  logic [W-1:0]  i_data_B  = '0;
  logic          i_stall   = 1'b0;
  logic          i_flush   = 1'b0;
  logic [W-1:0]  o_data_Hi;
  logic [W-1:0]  o_data_Lo;
  logic          o_con_mul;
  logic          o_busy;

  e_mult_pipe #(.WIDTH(W), .LATENCY(LAT)) dut (
    .clock     (clock),
    .n_rst     (n_rst),
    .i_con_mul (i_con_mul),
    .i_op      (i_op),
    .i_data_A  (i_data_A),
    .i_data_B  (i_data_B),
    .i_stall   (i_stall),
    .i_flush   (i_flush),
    .o_data_Hi (o_data_Hi),
    .o_data_Lo (o_data_Lo),
    .o_con_mul (o_con_mul),
    .o_busy    (o_busy)
  );

  localparam logic [2:0] MULTU = 3'd0, MULT = 3'd1, MADDU = 3'd2, MADD = 3'd3;
  localparam logic [2:0] MSUBU = 3'd4, MSUB = 3'd5, MTHI = 3'd6, MTLO = 3'd7;

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    int         cnt;
    logic [2:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } op_t;

  op_t          inflight[$];
  logic [63:0]  exp_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  function automatic logic [63:0] ref_prod(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub;
    if (op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  task automatic model_apply(input op_t t);
    logic [63:0] acc;
    logic [63:0] p;
    acc = {m_hi, m_lo};
    p   = ref_prod(t.op, t.a, t.b);
    if (t.op == MTHI)      m_hi = t.a;
    else if (t.op == MTLO) m_lo = t.a;
`ifdef MUL_ACC_EN
    else if (t.op == MADDU || t.op == MADD) {m_hi, m_lo} = acc + p;
    else if (t.op == MSUBU || t.op == MSUB) {m_hi, m_lo} = acc - p;
`endif
    else {m_hi, m_lo} = p;
  endtask

  // ---------------------------------------------------------------- driver
  // Drive one cycle of inputs, advance one edge, update the model, then check
  // all outputs 1 time unit after the edge.
  task automatic step(input logic con, input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic stall, input logic flush);
    bit          pulse;
    op_t         t;
    logic [63:0] e;
    i_con_mul = con;
    i_op      = op;
    i_data_A  = a;
    i_data_B  = b;
    i_stall   = stall;
    i_flush   = flush;
    @(posedge clock);
    pulse = 0;
    if (flush) begin
      inflight.delete();
    end else if (!stall) begin
      for (int i = 0; i < inflight.size(); i++) inflight[i].cnt--;
      if (inflight.size() > 0 && inflight[0].cnt == 0) begin
        t = inflight.pop_front();
        model_apply(t);
        pulse = 1;
        exp_q.push_back({m_hi, m_lo});
      end
      if (con) begin
        t.cnt = LAT;
        t.op  = op;
        t.a   = a;
        t.b   = b;
        inflight.push_back(t);
      end
    end
    #1;
    check("con_mul", o_con_mul, pulse);
    check("busy", o_busy, inflight.size() != 0);
    check("hi", o_data_Hi, m_hi);
    check("lo", o_data_Lo, m_lo);
    if (o_con_mul) begin
      if (exp_q.size() == 0) check("wb_unexpected", o_con_mul, 0);
      else begin
        e = exp_q.pop_front();
        check("wb_value", {o_data_Hi, o_data_Lo}, e);
      end
    end else if (pulse && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, MULTU, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    i_con_mul = 1'b0;
    i_stall   = 1'b0;
    i_flush   = 1'b0;
    n_rst     = 1'b0;
    #1;
    check("rst_hi", o_data_Hi, 0);
    check("rst_lo", o_data_Lo, 0);
    check("rst_con", o_con_mul, 0);
    check("rst_busy", o_busy, 0);
    inflight.delete();
    exp_q.delete();
    m_hi = '0;
    m_lo = '0;
    @(posedge clock);
    @(posedge clock);
    #1 n_rst = 1'b1;
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------- stimulus
  logic [W-1:0] corners [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

  function automatic logic [W-1:0] pick();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    logic [W-1:0] exp_lo3, exp_hi4a, exp_lo4a;
`ifdef MUL_ACC_EN
    exp_lo3  = 32'd17;
    exp_hi4a = 32'hFFFFFFFF;
    exp_lo4a = 32'hFFFFFFFF;
`else
    exp_lo3  = 32'd12;
    exp_hi4a = 32'h0;
    exp_lo4a = 32'h1;
`endif
    #1;
    do_reset();

    // 1: MULTU max*max, pulse after edge 7, busy through edges 0..6
    step(1, MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    idle(LAT - 1);
    check("s1_busy_e6", o_busy, 1);
    idle(1);
    check("s1_pulse", o_con_mul, 1);
    check("s1_hi", o_data_Hi, 32'hFFFFFFFE);
    check("s1_lo", o_data_Lo, 32'h00000001);
    idle(1);
    check("s1_busy_done", o_busy, 0);

    // 2: signed vs unsigned interpretation
    step(1, MULT, 32'hFFFFFFFF, 32'h2, 0, 0);
    idle(LAT);
    check("s2_mult_hi", o_data_Hi, 32'hFFFFFFFF);
    check("s2_mult_lo", o_data_Lo, 32'hFFFFFFFE);
    step(1, MULTU, 32'hFFFFFFFF, 32'h2, 0, 0);
    idle(LAT);
    check("s2_multu_hi", o_data_Hi, 32'h1);
    check("s2_multu_lo", o_data_Lo, 32'hFFFFFFFE);

    // 3: dependent back-to-back moves and accumulate
    step(1, MTLO, 32'd5, 32'd0, 0, 0);
    step(1, MTHI, 32'd0, 32'd0, 0, 0);
    step(1, MADDU, 32'd3, 32'd4, 0, 0);
    idle(LAT + 1);
    check("s3_hi", o_data_Hi, 32'd0);
    check("s3_lo", o_data_Lo, exp_lo3);

    // 4: accumulate wrap-around from zero
    do_reset();
    step(1, MSUB, 32'd1, 32'd1, 0, 0);
    idle(LAT);
    check("s4_msub_hi", o_data_Hi, exp_hi4a);
    check("s4_msub_lo", o_data_Lo, exp_lo4a);
    step(1, MADDU, 32'd1, 32'd1, 0, 0);
    idle(LAT);
    check("s4_wrap_hi", o_data_Hi, 32'd0);
`ifdef MUL_ACC_EN
    check("s4_wrap_lo", o_data_Lo, 32'd0);
`else
    check("s4_wrap_lo", o_data_Lo, 32'd1);
`endif

    // 5: stall at edges 2..4 with a request held through the stall
    do_reset();
    step(1, MULTU, 32'd6, 32'd7, 0, 0);      // edge 0
    idle(1);                                  // edge 1
    for (int i = 0; i < 3; i++) step(1, MTLO, 32'd9, 32'd0, 1, 0);  // edges 2..4
    step(1, MTLO, 32'd9, 32'd0, 0, 0);       // edge 5: accepted now
    idle(4);                                  // edges 6..9
    check("s5_no_early", o_con_mul, 0);
    idle(1);                                  // edge 10
    check("s5_pulse", o_con_mul, 1);
    check("s5_lo", o_data_Lo, 32'd42);
    idle(3);
    check("s5_held_lo", o_data_Lo, 32'd9);

    // 6a: flush at edge 3 together with a new request
    do_reset();
    step(1, MTLO, 32'h55, 32'd0, 0, 0);
    idle(LAT);
    step(1, MULTU, 32'd6, 32'd7, 0, 0);      // edge 0
    idle(2);
    step(1, MULTU, 32'd3, 32'd3, 0, 1);      // edge 3 flush + request
    check("s6_busy_flush", o_busy, 0);
    idle(10);
    check("s6_lo_kept", o_data_Lo, 32'h55);

    // 6b: reset mid-op
    step(1, MULTU, 32'd5, 32'd5, 0, 0);
    idle(3);
    do_reset();
    idle(10);
    check("s6_lo_after_rst", o_data_Lo, 32'd0);

    // flush at the writeback edge and flush during stall
    step(1, MTHI, 32'hABCD, 32'd0, 0, 0);
    idle(LAT - 1);
    step(0, MULTU, 32'd0, 32'd0, 1, 1);
    idle(3);
    check("wb_edge_flush_hi", o_data_Hi, 32'd0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), pick(), pick(),
           $urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0);
    end
    idle(LAT + 2);
    check("drain", 64'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
